// File: rtl/word_cpu.sv
// Parametrised N-bit accumulator CPU: fetch/decode/execute FSM, internal data memory and register bank.
// Optional WORD_CPU_CARRY_EN adds a carry flag and carry-in for ADD/SUB.
module word_cpu #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DM_DEPTH      = 16,
  parameter int INT_REGS_No   = 4,
  parameter int EXT_REGS_No   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [ADDRESS_WIDTH-1:0]          pm_addr,
  input  logic [ADDRESS_WIDTH+3:0]          pm_data_in,
  input  logic [EXT_REGS_No*DATA_WIDTH-1:0] ext_registers_in,
  output logic [INT_REGS_No*DATA_WIDTH-1:0] int_registers_out,
  input  logic [DATA_WIDTH-1:0]             sem_data_in,
  input  logic                              sem_data_valid_in,
  output logic                              sem_data_read,
  output logic [DATA_WIDTH-1:0]             sem_data_out,
  output logic                              sem_data_valid_out,
  input  logic                              sem_data_full,
  output logic                              zero_flag,
  output logic                              carry_flag,
  output logic                              halted,
  output logic [3:0]                        state
);

  // state    | meaning
  // FETCH    | pm_addr carries pc, program memory read in flight
  // DECODE   | latch instruction from pm_data_in
  // EXEC     | execute, advance pc
  // WAIT_IN  | wait for inbound semaphore word
  // WAIT_OUT | wait for outbound sink to accept
  // HALT     | stopped until reset
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_WAIT_IN  = 4'd3,
    S_WAIT_OUT = 4'd4,
    S_HALT     = 4'd5
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7, OP_XOR = 4'h8, OP_RDX = 4'h9;
  localparam logic [3:0] OP_WRR  = 4'hA, OP_JMP = 4'hB, OP_JZ  = 4'hC;
  localparam logic [3:0] OP_SIN  = 4'hD, OP_SOUT = 4'hE, OP_HALT = 4'hF;

  localparam int DM_AW  = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;
  localparam int EXT_AW = (EXT_REGS_No > 1) ? $clog2(EXT_REGS_No) : 1;
  localparam int INT_AW = (INT_REGS_No > 1) ? $clog2(INT_REGS_No) : 1;
  localparam logic [ADDRESS_WIDTH:0] EXT_N = (ADDRESS_WIDTH+1)'(EXT_REGS_No);
  localparam logic [ADDRESS_WIDTH:0] INT_N = (ADDRESS_WIDTH+1)'(INT_REGS_No);

  state_t state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH+3:0] ir;
  logic [DATA_WIDTH-1:0]    acc, acc_nxt, dm_rd, rdx_val, ldi_val, alu_add, alu_sub;
  logic                     acc_we, take_jump;
  logic [3:0]               opcode;
  logic [ADDRESS_WIDTH-1:0] operand;
  logic [DM_AW-1:0]         dm_idx;

  logic [DATA_WIDTH-1:0] dm       [DM_DEPTH];
  logic [DATA_WIDTH-1:0] ext_arr  [EXT_REGS_No];
  logic [DATA_WIDTH-1:0] int_regs [INT_REGS_No];

  for (genvar i = 0; i < EXT_REGS_No; i++) begin : g_ext
    assign ext_arr[i] = ext_registers_in[i*DATA_WIDTH +: DATA_WIDTH];
  end
  for (genvar i = 0; i < INT_REGS_No; i++) begin : g_int
    assign int_registers_out[i*DATA_WIDTH +: DATA_WIDTH] = int_regs[i];
  end

  assign opcode    = ir[ADDRESS_WIDTH+3:ADDRESS_WIDTH];
  assign operand   = ir[ADDRESS_WIDTH-1:0];
  assign dm_idx    = operand[DM_AW-1:0];
  assign dm_rd     = dm[dm_idx];
  assign ldi_val   = DATA_WIDTH'(operand);
  assign rdx_val   = ({1'b0, operand} < EXT_N) ? ext_arr[operand[EXT_AW-1:0]] : '0;
  assign take_jump = (opcode == OP_JMP) || (opcode == OP_JZ && zero_flag);
  assign pm_addr   = pc;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);

`ifdef WORD_CPU_CARRY_EN
  logic                  carry_q;
  logic [DATA_WIDTH:0]   add_full, sub_full;
  // Top bit of the widened difference is the borrow out.
  assign add_full = {1'b0, acc} + {1'b0, dm_rd} + (DATA_WIDTH+1)'(carry_q);
  assign sub_full = {1'b0, acc} - {1'b0, dm_rd} - (DATA_WIDTH+1)'(carry_q);
  assign alu_add  = add_full[DATA_WIDTH-1:0];
  assign alu_sub  = sub_full[DATA_WIDTH-1:0];
  assign carry_flag = carry_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      case (opcode)
        OP_LDI:  carry_q <= 1'b0;
        OP_ADD:  carry_q <= add_full[DATA_WIDTH];
        OP_SUB:  carry_q <= sub_full[DATA_WIDTH];
        default: ;
      endcase
    end
  end
`else
  assign alu_add    = acc + dm_rd;
  assign alu_sub    = acc - dm_rd;
  assign carry_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_SIN:  state_d = S_WAIT_IN;
          OP_SOUT: state_d = S_WAIT_OUT;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_WAIT_IN:  if (sem_data_valid_in) state_d = S_FETCH;
      S_WAIT_OUT: if (!sem_data_full) state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Every accumulator write funnels through here so the zero flag tracks it.
  always_comb begin
    acc_we  = 1'b0;
    acc_nxt = acc;
    if (state_q == S_EXEC) begin
      acc_we = 1'b1;
      case (opcode)
        OP_LDI:  acc_nxt = ldi_val;
        OP_LD:   acc_nxt = dm_rd;
        OP_ADD:  acc_nxt = alu_add;
        OP_SUB:  acc_nxt = alu_sub;
        OP_AND:  acc_nxt = acc & dm_rd;
        OP_OR:   acc_nxt = acc | dm_rd;
        OP_XOR:  acc_nxt = acc ^ dm_rd;
        OP_RDX:  acc_nxt = rdx_val;
        default: acc_we  = 1'b0;
      endcase
    end else if (state_q == S_WAIT_IN && sem_data_valid_in) begin
      acc_we  = 1'b1;
      acc_nxt = sem_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc                 <= '0;
      ir                 <= '0;
      acc                <= '0;
      zero_flag          <= 1'b0;
      sem_data_out       <= '0;
      sem_data_read      <= 1'b0;
      sem_data_valid_out <= 1'b0;
      for (int i = 0; i < INT_REGS_No; i++) int_regs[i] <= '0;
    end else begin
      sem_data_read      <= 1'b0;
      sem_data_valid_out <= 1'b0;
      if (acc_we) begin
        acc       <= acc_nxt;
        zero_flag <= (acc_nxt == '0);
      end
      case (state_q)
        S_DECODE: ir <= pm_data_in;
        S_EXEC: begin
          if (take_jump) pc <= operand;
          else           pc <= pc + ADDRESS_WIDTH'(1);
          if (opcode == OP_WRR && {1'b0, operand} < INT_N)
            int_regs[operand[INT_AW-1:0]] <= acc;
        end
        S_WAIT_IN: if (sem_data_valid_in) sem_data_read <= 1'b1;
        S_WAIT_OUT: begin
          if (!sem_data_full) begin
            sem_data_out       <= acc;
            sem_data_valid_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Data memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state_q == S_EXEC && opcode == OP_ST) dm[dm_idx] <= acc;
  end

endmodule
